// File: rtl/multi_channel_sync_fifo.sv
// multi_channel_sync_fifo: single-clock FIFO with NUM_CH independent queues sharing one write and one read port
module multi_channel_sync_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int NUM_CH       = 4,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               valid,
  input  logic [$clog2(NUM_CH)-1:0]          wch,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               ren,
  input  logic [$clog2(NUM_CH)-1:0]          rch,
  input  logic                               err_clr,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               valid_out,
  output logic [NUM_CH-1:0]                  full,
  output logic [NUM_CH-1:0]                  empty,
  output logic [NUM_CH-1:0]                  almost_full,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   count,
  output logic                               overflow,
  output logic                               underflow
);
  localparam int DEPTH    = 2**ADDR_WIDTH;
  localparam int CH_WIDTH = $clog2(NUM_CH);
  localparam int CNT_W    = ADDR_WIDTH + 1;
  localparam logic [CH_WIDTH:0] NCH = NUM_CH[CH_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [NUM_CH*DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr [NUM_CH];
  logic [ADDR_WIDTH-1:0] r_rptr [NUM_CH];
  logic [CNT_W-1:0]      r_cnt  [NUM_CH];
  logic                  w_wacc, w_racc;
  logic [NUM_CH-1:0]     w_wr, w_rd;

  // status flags decode straight from the registered counts
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign full[c]        = r_cnt[c] == CNT_W'(DEPTH);
    assign empty[c]       = r_cnt[c] == '0;
    assign almost_full[c] = r_cnt[c] >= CNT_W'(AFULL_THRESH);
    assign count[c*CNT_W +: CNT_W] = r_cnt[c];
  end

  // acceptance uses registered full/empty, so a read never frees space for a same-cycle write and there is no bypass
  assign w_wacc = valid && ({1'b0, wch} < NCH) && !full[wch];
  assign w_racc = ren && ({1'b0, rch} < NCH) && !empty[rch];
  assign w_wr   = w_wacc ? NUM_CH'(1) << wch : '0;
  assign w_rd   = w_racc ? NUM_CH'(1) << rch : '0;

  // per-channel pointers wrap naturally at DEPTH; count moves by write minus read
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
        if (w_rd[c]) r_rptr[c] <= r_rptr[c] + 1'b1;
        r_cnt[c] <= r_cnt[c] + {{ADDR_WIDTH{1'b0}}, w_wr[c]} - {{ADDR_WIDTH{1'b0}}, w_rd[c]};
      end
    end
  end

  // storage: channel index forms the upper address bits, so channel c owns c*DEPTH..c*DEPTH+DEPTH-1
  always_ff @(posedge clk) begin
    if (w_wacc) r_mem[{wch, r_wptr[wch]}] <= data_in;
  end

  // registered read port with one-cycle latency; data_out holds when no read is accepted
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= w_racc;
      if (w_racc) data_out <= r_mem[{rch, r_rptr[rch]}];
    end
  end

  // sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (valid && !w_wacc) || (overflow && !err_clr);
      underflow <= (ren && !w_racc) || (underflow && !err_clr);
    end
  end
endmodule
